onehot_rr_arbiter: RTL and testbench

- Upstream stage for the 8-to-3 behavioural encoder (encod83beh).
- Collects 8 single-cycle request pulses into a pending register.
- Picks one pending request at a time, round-robin, and presents it as a registered one-hot vector `out[7:0]` with `en`. Both drive the encoder's `in` and `en` directly.
- Holds each grant until the consumer acknowledges it. This keeps the encoder input at exactly zero or one hot bit.

---
 rtl/onehot_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//   Upstream stage for the 8-to-3 behavioural encoder (encod83beh). Single-cycle
//   request pulses are collected into a pending register. One pending request
//   at a time is granted, in round-robin order, as a registered one-hot vector.
//   Each grant is held until the consumer acknowledges it, so the encoder input
//   is always zero or exactly one hot bit.
//
//   Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
//   priority (index 0 highest). In that build the pointer stays at 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_in     [7:0] request pulses; bit i high for any cycle marks request i pending
//   ack        consumer took the current grant; ignored while en=0
//   out        [7:0] registered one-hot grant, drives encoder `in`; zero when en=0
//   en         grant valid, drives encoder `en`
//   pending    [7:0] pending request register (status)
//   grant_cnt  [7:0] completed grants (ack accepted), wraps 255->0
module onehot_rr_arbiter #(
    parameter int N = 8  // must stay 8 to match the encoder
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         ack,
    output logic [N-1:0] out,
    output logic         en,
    output logic [N-1:0] pending,
    output logic [7:0]   grant_cnt
);

    localparam int PW = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr, ptr_next, ptr_adv;
    logic [PW-1:0] scan_idx, sel_idx;
    logic          sel_found;
    logic [N-1:0]  out_next, clear_mask;
    logic          en_next;
    logic [7:0]    cnt_next;

    // First pending bit at or above ptr, wrapping 7->0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = ptr + PW'(i);
            if (!sel_found && pending[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Pointer pinned at 0: the scan above degenerates to lowest-index-first.
    assign ptr_adv = '0;
`else
    // Pointer advances to one past the granted index, recovered from out.
    always_comb begin
        ptr_adv = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (out[i]) begin
                ptr_adv = PW'(i + 1);
            end
        end
    end
`endif

    always_comb begin
        state_next = state;
        out_next   = out;
        en_next    = en;
        ptr_next   = ptr;
        cnt_next   = grant_cnt;
        clear_mask = '0;
        case (state)
            IDLE: begin
                out_next = '0;
                en_next  = 1'b0;
                if (sel_found) begin
                    out_next[sel_idx] = 1'b1;
                    en_next           = 1'b1;
                    state_next        = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    clear_mask = out;
                    ptr_next   = ptr_adv;
                    cnt_next   = grant_cnt + 8'd1;
                    out_next   = '0;
                    en_next    = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                out_next   = '0;
                en_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            out       <= '0;
            en        <= 1'b0;
            pending   <= '0;
            grant_cnt <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            out       <= out_next;
            en        <= en_next;
            // A new request on the bit being cleared keeps it pending.
            pending   <= (pending & ~clear_mask) | req_in;
            grant_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Testbench for onehot_rr_arbiter: directed stimulus pushes the expected grant
// sequence into a scoreboard queue; a monitor pops and compares on every rising
// en and checks the output invariants each cycle.
module tb_onehot_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic       ack;
    logic [7:0] out;
    logic       en;
    logic [7:0] pending;
    logic [7:0] grant_cnt;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .ack       (ack),
        .out       (out),
        .en        (en),
        .pending   (pending),
        .grant_cnt (grant_cnt)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [7:0] v);
        req_in = v;
        tick(1);
        req_in = 8'h00;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic wait_grant(input string name, input int max);
        int k;
        k = 0;
        while (!en && k < max) begin
            tick(1);
            k++;
        end
        check(name, {7'd0, en}, 8'h01);
    endtask

    task automatic wait_cnt(input string name, input logic [7:0] target, input int max);
        int k;
        k = 0;
        while (grant_cnt !== target && k < max) begin
            tick(1);
            k++;
        end
        check(name, grant_cnt, target);
    endtask

    // Monitor: scoreboard compare on each new grant, invariants every cycle.
    initial begin
        logic       en_q;
        logic [7:0] e;
        en_q = 1'b0;
        forever begin
            @(negedge clk);
            check("onehot0", {7'd0, $onehot0(out)}, 8'h01);
            if (!en) check("out_zero_when_idle", out, 8'h00);
            if (en && !en_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", out, 8'h00);
                end else begin
                    e = sb.pop_front();
                    check("grant", out, e);
                end
            end
            en_q = en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        // Reset with all requests asserted.
        rst_n  = 1'b0;
        req_in = 8'hFF;
        ack    = 1'b0;
        tick(3);
        check("reset_out", out, 8'h00);
        check("reset_en", {7'd0, en}, 8'h00);
        check("reset_pending", pending, 8'h00);
        check("reset_cnt", grant_cnt, 8'h00);
        rst_n  = 1'b1;
        req_in = 8'h00;
        tick(1);

        // First request: pending after one edge, grant after the second.
        sb.push_back(8'h01);
        pulse_req(8'h01);
        check("lat_en_early", {7'd0, en}, 8'h00);
        check("lat_pending", pending, 8'h01);
        tick(1);
        check("lat_en", {7'd0, en}, 8'h01);
        check("lat_out", out, 8'h01);
        pulse_ack();
        check("first_cnt", grant_cnt, 8'd1);
        check("first_en_clr", {7'd0, en}, 8'h00);
        check("first_pend_clr", pending, 8'h00);

        // Single request held without ack.
        sb.push_back(8'h04);
        pulse_req(8'h04);
        wait_grant("single_grant", 5);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_out", out, 8'h04);
            check("hold_en", {7'd0, en}, 8'h01);
        end
        pulse_ack();
        check("single_en", {7'd0, en}, 8'h00);
        check("single_out", out, 8'h00);
        check("single_pend", pending, 8'h00);
        check("single_cnt", grant_cnt, 8'd2);

        // Round-robin sweep from ptr=0 with ack tied high.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rr_cnt_reset", grant_cnt, 8'd0);
        b = 8'h01;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(b);
            b = b << 1;
        end
        ack = 1'b1;
        pulse_req(8'hFF);
        wait_cnt("rr_cnt", 8'd8, 40);
        tick(1);
        ack = 1'b0;
        check("rr_en_idle", {7'd0, en}, 8'h00);
        check("rr_pend", pending, 8'h00);

        // Fairness: after granting bit 5, ptr=6.
        sb.push_back(8'h20);
        pulse_req(8'h20);
        wait_grant("fair_grant5", 5);
        pulse_ack();
`ifdef ARB_FIXED_PRIO_EN
        sb.push_back(8'h02);
        sb.push_back(8'h40);
`else
        sb.push_back(8'h40);
        sb.push_back(8'h02);
`endif
        ack = 1'b1;
        pulse_req(8'h42);
        wait_cnt("fair_cnt", 8'd11, 20);
        tick(1);
        ack = 1'b0;
        check("fair_pend", pending, 8'h00);

        // Set/clear collision on bit 3.
        sb.push_back(8'h08);
        pulse_req(8'h08);
        wait_grant("col_grant", 5);
        sb.push_back(8'h08);
        ack    = 1'b1;
        req_in = 8'h08;
        tick(1);
        ack    = 1'b0;
        req_in = 8'h00;
        check("col_en_idle", {7'd0, en}, 8'h00);
        check("col_pend", pending, 8'h08);
        check("col_cnt", grant_cnt, 8'd12);
        tick(1);
        check("col_regrant_en", {7'd0, en}, 8'h01);
        check("col_regrant_out", out, 8'h08);
        pulse_ack();
        check("col_cnt2", grant_cnt, 8'd13);
        check("col_pend_clr", pending, 8'h00);

        // Stray ack while idle.
        pulse_ack();
        check("stray_en", {7'd0, en}, 8'h00);
        check("stray_pend", pending, 8'h00);
        check("stray_cnt", grant_cnt, 8'd13);

        // ptr=4 after the bit-3 grant: bit 5 before bit 2.
`ifdef ARB_FIXED_PRIO_EN
        sb.push_back(8'h04);
        sb.push_back(8'h20);
`else
        sb.push_back(8'h20);
        sb.push_back(8'h04);
`endif
        pulse_req(8'h24);
        wait_grant("ptr_grant_a", 5);
        pulse_ack();
        check("ptr_cnt", grant_cnt, 8'd14);
        wait_grant("ptr_grant_b", 5);

        // Asynchronous reset in the middle of that grant.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_en", {7'd0, en}, 8'h00);
        check("arst_out", out, 8'h00);
        check("arst_cnt", grant_cnt, 8'd0);
        check("arst_pend", pending, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_reset_en", {7'd0, en}, 8'h00);
        check("sb_empty", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
